uart_prog_loader: RTL and testbench

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

---
 rtl/uart_prog_loader.sv | 185 ++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receives a program over a UART line, packs bytes into
// little-endian 32-bit words and writes them to a word-addressed memory until
// a sentinel word arrives or the address space is full.
// Frame format: 8N1 by default; define UART_PROG_LOADER_PARITY_EN for 8E1.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 347,
  parameter int unsigned ADDR_W       = 8,
  parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              rx_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              prog_done_o,
  output logic              frame_err_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PROG_LOADER_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic             rx_q1, rx_q2;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic [1:0]       byte_cnt;
  logic [23:0]      word;
  logic [ADDR_W-1:0] addr;
  logic [31:0]      full_word;
  logic             half_tick, bit_tick;
  logic             sample_bit, byte_ok, byte_bad, stop_good;
`ifdef UART_PROG_LOADER_PARITY_EN
  logic             par_err, sample_par;
`endif

  assign half_tick = (baud_cnt == CNT_W'(HALF - 1));
  assign bit_tick  = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign full_word = {shift, word};

  // Two-flop synchronizer on the serial line, idling high
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_q1 <= 1'b1;
      rx_q2 <= 1'b1;
    end else begin
      rx_q1 <= rx_i;
      rx_q2 <= rx_q1;
    end
  end

  // FSM state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and per-cycle control decode
  always_comb begin
    state_nxt  = state;
    sample_bit = 1'b0;
    byte_ok    = 1'b0;
    byte_bad   = 1'b0;
    stop_good  = rx_q2;
`ifdef UART_PROG_LOADER_PARITY_EN
    sample_par = 1'b0;
    stop_good  = rx_q2 && !par_err;
`endif
    case (state)
      S_IDLE: if (!rx_q2) state_nxt = S_START;
      S_START: begin
        // A line that is high again at mid start bit was only a glitch
        if (half_tick) state_nxt = rx_q2 ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_tick) begin
          sample_bit = 1'b1;
`ifdef UART_PROG_LOADER_PARITY_EN
          if (bit_cnt == 3'd7) state_nxt = S_PARITY;
`else
          if (bit_cnt == 3'd7) state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_PROG_LOADER_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          sample_par = 1'b1;
          state_nxt  = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_tick) begin
          state_nxt = S_IDLE;
          if (stop_good) begin
            byte_ok = 1'b1;
            if (byte_cnt == 2'd3 && full_word == END_WORD) state_nxt = S_DONE;
          end else begin
            byte_bad = 1'b1;
          end
        end
      end
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    // Memory full: the write to the last address ends loading
    if (mem_we_o && addr == ADDR_MAX) state_nxt = S_DONE;
  end

  // Baud counter restarts on every state change and every bit period
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      baud_cnt <= '0;
    end else if (state_nxt != state || state == S_IDLE || state == S_DONE || bit_tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

  // Bit shifting, word assembly, memory write and status flags
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bit_cnt     <= '0;
      shift       <= '0;
      byte_cnt    <= '0;
      word        <= '0;
      addr        <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      prog_done_o <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef UART_PROG_LOADER_PARITY_EN
      par_err     <= 1'b0;
`endif
    end else begin
      mem_we_o    <= 1'b0;
      prog_done_o <= (state_nxt == S_DONE);
      if (state == S_START) bit_cnt <= '0;
      if (sample_bit) begin
        shift   <= {rx_q2, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
`ifdef UART_PROG_LOADER_PARITY_EN
      if (state == S_START) par_err <= 1'b0;
      if (sample_par)       par_err <= rx_q2 ^ (^shift);
`endif
      if (byte_bad) frame_err_o <= 1'b1;
      if (byte_ok) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0: word[7:0]   <= shift;
          2'd1: word[15:8]  <= shift;
          2'd2: word[23:16] <= shift;
          default: begin
            if (full_word != END_WORD) begin
              mem_we_o    <= 1'b1;
              mem_addr_o  <= addr;
              mem_wdata_o <= full_word;
            end
          end
        endcase
      end
      // Advance the address after each strobe; never wrap past the top
      if (mem_we_o && addr != ADDR_MAX) addr <= addr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed and randomized program downloads checked
// against a queue-based model of the loader's byte/word/address rules.
module tb_uart_prog_loader;

  localparam int unsigned CPB    = 4;
  localparam int unsigned ADDR_W = 2;
  localparam logic [31:0] END_W  = 32'h0000_0FFF;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              prog_done;
  logic              frame_err;

  int vectors    = 0;
  int miscompares = 0;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .END_WORD(END_W)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .rx_i       (rx),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .prog_done_o(prog_done),
    .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  // Write monitor: records strobes, wide strobes and output changes without a strobe
  wr_t               got_q[$];
  int                wide_cnt = 0;
  int                hold_cnt = 0;
  logic              prev_we  = 1'b0;
  logic [ADDR_W-1:0] last_a   = '0;
  logic [31:0]       last_d   = '0;
  always @(negedge clk) begin
    wr_t e;
    if (rst !== 1'b1) begin
      if (mem_we === 1'b1) begin
        if (prev_we === 1'b1) wide_cnt = wide_cnt + 1;
        e.a = mem_addr;
        e.d = mem_wdata;
        got_q.push_back(e);
      end else if (mem_addr !== last_a || mem_wdata !== last_d) begin
        hold_cnt = hold_cnt + 1;
      end
    end
    prev_we = mem_we;
    last_a  = mem_addr;
    last_d  = mem_wdata;
  end

  // Reference model: accepted bytes grouped into words, sentinel/full ends it
  logic [7:0] m_acc[$];
  wr_t        exp_q[$];
  int         m_addr;
  bit         m_done;
  bit         m_ferr;
  int         got_base, wide_base, hold_base;

  task automatic model_byte(input logic [7:0] b, input bit good);
    logic [31:0] w;
    wr_t e;
    if (m_done) return;
    if (!good) begin
      m_ferr = 1'b1;
      return;
    end
    m_acc.push_back(b);
    if (m_acc.size() == 4) begin
      w = {m_acc[3], m_acc[2], m_acc[1], m_acc[0]};
      m_acc.delete();
      if (w == END_W) begin
        m_done = 1'b1;
      end else begin
        e.a = ADDR_W'(m_addr);
        e.d = w;
        exp_q.push_back(e);
        m_addr++;
        if (m_addr == (1 << ADDR_W)) m_done = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_PROG_LOADER_PARITY_EN
    rx = ^b;
    repeat (CPB) @(negedge clk);
`endif
    rx = good_stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    model_byte(b, good_stop);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_frame(w[8*i +: 8], 1'b1);
  endtask

  task automatic scen_start();
    m_acc.delete();
    exp_q.delete();
    m_addr    = 0;
    m_done    = 1'b0;
    m_ferr    = 1'b0;
    got_base  = got_q.size();
    wide_base = wide_cnt;
    hold_base = hold_cnt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    scen_start();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_we"},    64'(mem_we),    64'd0);
    chk({tag, "_addr"},  64'(mem_addr),  64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_done"},  64'(prog_done), 64'd0);
    chk({tag, "_ferr"},  64'(frame_err), 64'd0);
  endtask

  task automatic scen_finish(input string tag);
    int n;
    int ng;
    n = 0;
    while (prog_done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    ng = got_q.size() - got_base;
    chk({tag, "_done"},   64'(prog_done), 64'(m_done));
    chk({tag, "_ferr"},   64'(frame_err), 64'(m_ferr));
    chk({tag, "_nwr"},    64'(ng),        64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ng; i++) begin
      chk({tag, "_addr"}, 64'(got_q[got_base + i].a), 64'(exp_q[i].a));
      chk({tag, "_data"}, 64'(got_q[got_base + i].d), 64'(exp_q[i].d));
    end
    chk({tag, "_wide"}, 64'(wide_cnt - wide_base), 64'd0);
    chk({tag, "_hold"}, 64'(hold_cnt - hold_base), 64'd0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == END_W) w = w ^ 32'd1;
    return w;
  endfunction

  initial begin
    int nw;
    rst = 1'b0;
    rx  = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    scen_start();

    // Single word then sentinel
    send_word(32'h0000_0013);
    send_word(END_W);
    scen_finish("one_word");

    // Two words then sentinel
    do_reset();
    send_word(32'hDEAD_BEEF);
    send_word(32'h00A0_0093);
    send_word(END_W);
    scen_finish("two_words");

    // Five words: memory fills after four, fifth ignored
    do_reset();
    for (int i = 0; i < 5; i++) send_word(rand_word());
    scen_finish("full_mem");

    // Short low glitch in idle must not start a byte
    do_reset();
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    chk("glitch_ferr", 64'(frame_err), 64'd0);
    chk("glitch_nwr",  64'(got_q.size() - got_base), 64'd0);
    send_word(rand_word());
    send_word(END_W);
    scen_finish("glitch");

    // Bad stop bit: byte dropped, flag set, word assembly unaffected
    do_reset();
    send_frame(8'h55, 1'b0);
    chk("ferr_set", 64'(frame_err), 64'd1);
    send_word(32'h1234_5678);
    send_word(END_W);
    scen_finish("bad_stop");

    // Reset mid-word clears outputs and restarts at address 0
    do_reset();
    send_word(rand_word());
    send_frame(8'hA5, 1'b0);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midreset");
    rst = 1'b0;
    @(negedge clk);
    scen_start();
    send_word(32'hCAFE_0001);
    send_word(END_W);
    scen_finish("after_reset");

    // Randomized downloads with occasional framing errors
    for (int it = 0; it < 6; it++) begin
      do_reset();
      nw = $urandom_range(0, 5);
      for (int k = 0; k < nw; k++) begin
        if ($urandom_range(0, 3) == 0) send_frame(8'($urandom), 1'b0);
        send_word(rand_word());
      end
      send_word(END_W);
      scen_finish("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
